// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//
// Purpose: turns the free-running LFSR value into a legal food cell. On each
// spawn request a candidate cell is sampled and the snake-body store is asked
// whether it is occupied. After MAX_TRIES occupied random samples the search
// falls back to a linear scan from the last random candidate. If every cell
// is occupied the block reports fail.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   spawn_req           request a new food cell (sampled only when idle)
//   rand_num            LFSR value, changes every cycle
//   occ_query_valid     one-cycle occupancy query pulse
//   occ_query_x/y       queried cell
//   occ_resp_valid/hit  responder strobe and "cell occupied" flag
//   food_x/y            committed food cell
//   food_valid          food_x/y hold a committed free cell
//   busy                spawn in progress
//   fail                grid full, no free cell found
//
// state | meaning
// IDLE  | waiting for spawn_req, outputs held
// QUERY | occupancy query pulse for the current candidate
// WAIT  | waiting for the responder's answer (no timeout)
// -----------------------------------------------------------------------------
module food_spawner #(
    parameter int unsigned X_BITS    = 5,
    parameter int unsigned Y_BITS    = 4,
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned INIT_POS  = 132
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spawn_req,
    input  logic [X_BITS+Y_BITS-1:0] rand_num,
    output logic                     occ_query_valid,
    output logic [X_BITS-1:0]        occ_query_x,
    output logic [Y_BITS-1:0]        occ_query_y,
    input  logic                     occ_resp_valid,
    input  logic                     occ_resp_hit,
    output logic [X_BITS-1:0]        food_x,
    output logic [Y_BITS-1:0]        food_y,
    output logic                     food_valid,
    output logic                     busy,
    output logic                     fail
);

    localparam int unsigned CW = X_BITS + Y_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] QUERY = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [CW-1:0] INIT_C    = CW'(INIT_POS);
    localparam logic [7:0]    TRIES_MAX = 8'(MAX_TRIES);
    // Last scan step: every cell other than the last random candidate checked.
    localparam logic [CW-1:0] SCAN_LAST = {CW{1'b1}};

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cand;
    logic [7:0]        r_tries;
    logic              r_scan;
    logic [CW-1:0]     r_scan_cnt;
    logic [X_BITS-1:0] r_food_x;
    logic [Y_BITS-1:0] r_food_y;
    logic              r_food_valid;
    logic              r_busy;
    logic              r_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_tries      <= '0;
            r_scan       <= 1'b0;
            r_scan_cnt   <= '0;
            r_food_x     <= INIT_C[X_BITS-1:0];
            r_food_y     <= INIT_C[CW-1:X_BITS];
            r_food_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (spawn_req) begin
                        r_cand       <= rand_num;
                        r_tries      <= 8'd1;
                        r_scan       <= 1'b0;
                        r_scan_cnt   <= '0;
                        r_busy       <= 1'b1;
                        r_food_valid <= 1'b0;
                        r_fail       <= 1'b0;
                        r_state      <= QUERY;
                    end
                end
                QUERY: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (occ_resp_valid) begin
                        if (!occ_resp_hit) begin
                            r_food_x     <= r_cand[X_BITS-1:0];
                            r_food_y     <= r_cand[CW-1:X_BITS];
                            r_food_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= IDLE;
                        end else if (!r_scan) begin
                            if (r_tries < TRIES_MAX) begin
                                // rand_num has stepped since the last sample
                                r_cand  <= rand_num;
                                r_tries <= r_tries + 8'd1;
                            end else begin
                                r_scan     <= 1'b1;
                                r_cand     <= r_cand + 1'b1;
                                r_scan_cnt <= {{(CW-1){1'b0}}, 1'b1};
                            end
                            r_state <= QUERY;
                        end else if (r_scan_cnt == SCAN_LAST) begin
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cand     <= r_cand + 1'b1;
                            r_scan_cnt <= r_scan_cnt + 1'b1;
                            r_state    <= QUERY;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign occ_query_valid = (r_state == QUERY);
    assign occ_query_x     = r_cand[X_BITS-1:0];
    assign occ_query_y     = r_cand[CW-1:X_BITS];
    assign food_x          = r_food_x;
    assign food_y          = r_food_y;
    assign food_valid      = r_food_valid;
    assign busy            = r_busy;
    assign fail            = r_fail;

endmodule

// File: tb/tb_food_spawner.sv
// -----------------------------------------------------------------------------
// tb_food_spawner
//
// Directed bench for food_spawner. The bench plays both the LFSR (rand_num)
// and the occupancy responder. Inputs change on the falling edge, outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_food_spawner;

    logic       clk;
    logic       rst_n;
    logic       spawn_req;
    logic [8:0] rand_num;
    logic       occ_query_valid;
    logic [4:0] occ_query_x;
    logic [3:0] occ_query_y;
    logic       occ_resp_valid;
    logic       occ_resp_hit;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       fail;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;
    int p0       = 0;

    food_spawner dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spawn_req       (spawn_req),
        .rand_num        (rand_num),
        .occ_query_valid (occ_query_valid),
        .occ_query_x     (occ_query_x),
        .occ_query_y     (occ_query_y),
        .occ_resp_valid  (occ_resp_valid),
        .occ_resp_hit    (occ_resp_hit),
        .food_x          (food_x),
        .food_y          (food_y),
        .food_valid      (food_valid),
        .busy            (busy),
        .fail            (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Query pulses are counted once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (occ_query_valid === 1'b1) pulses = pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a spawn from a falling edge; returns at the falling edge of the
    // QUERY cycle.
    task automatic do_spawn(input string tag, input logic [8:0] r, input bit hold);
        spawn_req = 1'b1;
        rand_num  = r;
        @(posedge clk);
        @(negedge clk);
        if (!hold) spawn_req = 1'b0;
        check({tag, ".busy"},  busy, 1);
        check({tag, ".fv"},    food_valid, 0);
        check({tag, ".fail"},  fail, 0);
    endtask

    // Called at the falling edge of a QUERY cycle. Checks the pulse and its
    // coordinates, then answers after 'delay' WAIT cycles. Returns at the
    // falling edge after the response edge.
    task automatic query_step(input string tag, input logic [8:0] exp_c, input logic hit,
                              input logic [8:0] nrand, input int delay);
        logic [4:0] ex;
        logic [3:0] ey;
        ex = exp_c[4:0];
        ey = exp_c[8:5];
        check({tag, ".qv"}, occ_query_valid, 1);
        check({tag, ".qx"}, occ_query_x, ex);
        check({tag, ".qy"}, occ_query_y, ey);
        rand_num = nrand;
        @(posedge clk);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, ".wait_qv"}, occ_query_valid, 0);
            check({tag, ".wait_qx"}, occ_query_x, ex);
            check({tag, ".wait_qy"}, occ_query_y, ey);
            if (i == delay - 1) begin
                occ_resp_valid = 1'b1;
                occ_resp_hit   = hit;
            end
            @(posedge clk);
        end
        @(negedge clk);
        occ_resp_valid = 1'b0;
        occ_resp_hit   = 1'b0;
    endtask

    initial begin
        logic [8:0] rv [8];
        logic [8:0] c;

        rst_n          = 1'b0;
        spawn_req      = 1'b0;
        rand_num       = 9'h000;
        occ_resp_valid = 1'b0;
        occ_resp_hit   = 1'b0;

        // 1. Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.fx",   food_x, 4);
        check("rst.fy",   food_y, 4);
        check("rst.fv",   food_valid, 1);
        check("rst.busy", busy, 0);
        check("rst.fail", fail, 0);
        check("rst.qv",   occ_query_valid, 0);
        check("rst.qx",   occ_query_x, 0);
        check("rst.qy",   occ_query_y, 0);
        check("rst.pulses", pulses, 0);

        // 2. Single free hit, minimum latency: 9'h0A3 -> x=3, y=5
        p0 = pulses;
        do_spawn("t2", 9'h0A3, 1'b0);
        query_step("t2.q", 9'h0A3, 1'b0, 9'h000, 1);
        check("t2.fv",   food_valid, 1);
        check("t2.busy", busy, 0);
        check("t2.fx",   food_x, 3);
        check("t2.fy",   food_y, 5);
        check("t2.pulses", pulses - p0, 1);

        // 3. Random retry: (16,0) hit, (0,1) hit, (31,15) free
        p0 = pulses;
        do_spawn("t3", 9'h010, 1'b0);
        query_step("t3.q1", 9'h010, 1'b1, 9'h020, 1);
        query_step("t3.q2", 9'h020, 1'b1, 9'h1FF, 1);
        query_step("t3.q3", 9'h1FF, 1'b0, 9'h000, 1);
        check("t3.fv", food_valid, 1);
        check("t3.fx", food_x, 31);
        check("t3.fy", food_y, 15);
        check("t3.pulses", pulses - p0, 3);

        // 4. Scan fallback with wrap: last random 9'h1FF -> scan (0,0), (1,0)
        rv[0] = 9'h101; rv[1] = 9'h0F0; rv[2] = 9'h055; rv[3] = 9'h1AA;
        rv[4] = 9'h033; rv[5] = 9'h0CC; rv[6] = 9'h111; rv[7] = 9'h1FF;
        p0 = pulses;
        do_spawn("t4", rv[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            query_step("t4.rnd", rv[k], 1'b1, (k < 7) ? rv[(k < 7) ? k + 1 : 0] : 9'h0AA, 1);
        end
        check("t4.busy_scan", busy, 1);
        query_step("t4.s1", 9'h000, 1'b1, 9'h0AA, 1);
        query_step("t4.s2", 9'h001, 1'b0, 9'h0AA, 1);
        check("t4.fv", food_valid, 1);
        check("t4.fx", food_x, 1);
        check("t4.fy", food_y, 0);
        check("t4.pulses", pulses - p0, 10);

        // 5. Grid full: 8 random + 511 scan queries, all occupied
        for (int k = 0; k < 7; k++) rv[k] = 9'(9'h100 + k);
        rv[7] = 9'h005;
        p0 = pulses;
        do_spawn("t5", rv[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            query_step("t5.rnd", rv[k], 1'b1, (k < 7) ? rv[(k < 7) ? k + 1 : 0] : 9'h000, 1);
        end
        c = rv[7];
        for (int s = 1; s <= 511; s++) begin
            c = c + 9'd1;
            query_step("t5.scan", c, 1'b1, 9'h000, 1);
        end
        check("t5.fail",   fail, 1);
        check("t5.fv",     food_valid, 0);
        check("t5.busy",   busy, 0);
        check("t5.pulses", pulses - p0, 519);
        repeat (3) @(negedge clk);
        check("t5.idle_qv",   occ_query_valid, 0);
        check("t5.fail_hold", fail, 1);
        // Next request clears fail and starts afresh: 9'h077 -> (23,3)
        do_spawn("t5r", 9'h077, 1'b0);
        query_step("t5r.q", 9'h077, 1'b0, 9'h000, 1);
        check("t5r.fail", fail, 0);
        check("t5r.fv",   food_valid, 1);
        check("t5r.fx",   food_x, 23);
        check("t5r.fy",   food_y, 3);

        // 6a. spawn_req held high through QUERY/WAIT: no restart
        p0 = pulses;
        do_spawn("t6a", 9'h0C8, 1'b1);
        query_step("t6a.q", 9'h0C8, 1'b0, 9'h1E1, 3);
        spawn_req = 1'b0;
        check("t6a.fx", food_x, 8);
        check("t6a.fy", food_y, 6);
        check("t6a.pulses", pulses - p0, 1);
        repeat (2) @(negedge clk);
        check("t6a.idle_busy", busy, 0);

        // 6b. Responder delays 5 cycles; coordinates stay put
        p0 = pulses;
        do_spawn("t6b", 9'h14D, 1'b0);
        query_step("t6b.q", 9'h14D, 1'b0, 9'h0F3, 5);
        check("t6b.fx", food_x, 13);
        check("t6b.fy", food_y, 10);
        check("t6b.pulses", pulses - p0, 1);

        // 6c. Reset during WAIT, then a late response
        do_spawn("t6c", 9'h0A0, 1'b0);
        check("t6c.qv", occ_query_valid, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6c.rst_fx",   food_x, 4);
        check("t6c.rst_fy",   food_y, 4);
        check("t6c.rst_fv",   food_valid, 1);
        check("t6c.rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        occ_resp_valid = 1'b1;
        occ_resp_hit   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        occ_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6c.late_fx",   food_x, 4);
        check("t6c.late_fy",   food_y, 4);
        check("t6c.late_fv",   food_valid, 1);
        check("t6c.late_busy", busy, 0);
        check("t6c.late_pulses", pulses - p0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
